// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. It produces one quotient bit per cycle
// and raises a single-cycle completion flag. Divide-by-zero and signed overflow complete directly without iterating.
module iterative_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      alu_opE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            validE,
  input  logic            flushE,
  output logic [XLEN-1:0] result_d,
  output logic            flagD,
  output logic            stall_div
);
  localparam logic [4:0]       OP_DIV   = 5'b01111;
  localparam logic [4:0]       OP_DIVU  = 5'b10000;
  localparam logic [4:0]       OP_REM   = 5'b10001;
  localparam logic [4:0]       OP_REMU  = 5'b10010;
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rem_q, is_rem_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic             flag_q, flag_d;

  logic            is_div_op, is_signed, is_rem_op, start, div_zero, overflow;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   rem_sh;
  logic            trial_ge;
  logic [XLEN-1:0] step_quo, step_rem, fix_quo, fix_rem;

  assign is_div_op = (alu_opE == OP_DIV) | (alu_opE == OP_DIVU) |
                     (alu_opE == OP_REM) | (alu_opE == OP_REMU);
  assign is_signed = (alu_opE == OP_DIV) | (alu_opE == OP_REM);
  assign is_rem_op = (alu_opE == OP_REM) | (alu_opE == OP_REMU);
  assign start     = validE & ~flushE & is_div_op & (state_q == IDLE);

  // Negating INT_MIN wraps to itself, which is the correct unsigned magnitude.
  assign mag_a    = (is_signed & SrcAE[XLEN-1]) ? -SrcAE : SrcAE;
  assign mag_b    = (is_signed & SrcBE[XLEN-1]) ? -SrcBE : SrcBE;
  assign div_zero = (SrcBE == '0);
  assign overflow = is_signed & (SrcAE == INT_MIN) & (SrcBE == '1);

  // The shifted partial remainder needs one extra bit when the divisor exceeds 2^(XLEN-1).
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign trial_ge = (rem_sh >= {1'b0, dvs_q});
  assign step_rem = trial_ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
  assign step_quo = {quo_q[XLEN-2:0], trial_ge};
  assign fix_quo  = neg_quo_q ? -step_quo : step_quo;
  assign fix_rem  = neg_rem_q ? -step_rem : step_rem;

  assign stall_div = ~rst & (((state_q == IDLE) & start) | (state_q == BUSY));
  assign result_d  = res_q;
  assign flagD     = flag_q;

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    flag_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_d  = is_rem_op;
          neg_quo_d = is_signed & (SrcAE[XLEN-1] ^ SrcBE[XLEN-1]);
          neg_rem_d = is_signed & SrcAE[XLEN-1];
          quo_d     = mag_a;
          dvs_d     = mag_b;
          rem_d     = '0;
          cnt_d     = CNT_INIT;
          if (div_zero) begin
            res_d   = is_rem_op ? SrcAE : '1;
            flag_d  = 1'b1;
            state_d = DONE;
          end else if (overflow) begin
            res_d   = is_rem_op ? '0 : INT_MIN;
            flag_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = is_rem_q ? fix_rem : fix_quo;
            flag_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      flag_q    <= flag_d;
    end
  end
endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Iterative radix-2 restoring divider for the RV32M ops DIV, DIVU, REM and REMU.
- Sits in the Execute stage beside the iterative multiplier. It is the producer side of the ALU's M-extension result/flag interface: it drives a result word and a one-cycle completion flag, which the ALU selects when the Execute opcode is a divide/remainder op.
- Asserts a stall to the hazard unit while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- alu_opE  in  5  Execute-stage ALU opcode: DIV=5'b01111, DIVU=5'b10000, REM=5'b10001, REMU=5'b10010
- SrcAE  in  XLEN  dividend (rs1)
- SrcBE  in  XLEN  divisor (rs2)
- validE  in  1  Execute-stage instruction valid (not a bubble)
- flushE  in  1  kill the Execute instruction; aborts any in-flight op
- result_d  out  XLEN  quotient or remainder
- flagD  out  1  result_d valid, single-cycle pulse
- stall_div  out  1  hold IF/ID/EX pipeline registers

Behaviour:
- start = validE & ~flushE & (alu_opE ∈ {DIV,DIVU,REM,REMU}) & (state==IDLE).
- Reset, asynchronous, at any time including mid-operation:
  - state=IDLE, result_d=0, flagD=0, counter=0, internal registers=0.
  - stall_div deasserts combinationally.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On start, latch the op, sign flags and operand magnitudes.
  - Signed ops (DIV, REM) use |x|; the magnitude of 0x80000000 is 0x80000000 taken as unsigned.
  - quotient register = |dividend|, remainder register = 0, counter = XLEN.
  - Next state is BUSY, except for the special cases below, which go directly to DONE.
- Special cases, detected in IDLE at start and completed without iteration:
  - Divisor==0: quotient = 0xFFFFFFFF, remainder = dividend (unmodified).
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- BUSY, one restoring step per cycle:
  - Form {rem,quo} << 1, then trial = rem − |divisor|.
  - If trial is non-negative: rem = trial and quo LSB = 1. Otherwise the shifted rem is kept and quo LSB = 0.
  - counter decrements each step. When counter reaches 1 → DONE.
- Sign fix-up on entry to DONE:
  - Quotient is negated if dividend sign XOR divisor sign (signed ops only).
  - Remainder takes the dividend's sign.
  - Unsigned ops perform no fix-up.
- DONE:
  - flagD=1 for exactly one cycle, with result_d = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Next state is IDLE unconditionally.
- result_d holds its value after DONE until the next completion.
- stall_div = (state==IDLE & start) | (state==BUSY), combinational.
  - stall_div is low in DONE, so the pipeline advances at the end of the DONE cycle with the ALU capturing result_d.
- Latency:
  - Start sampled at edge E0.
  - Normal path: BUSY for XLEN cycles (E1..E32), flagD high in the cycle after E32; 34 cycles from start to retirement.
  - Special path: flagD high in the cycle after E0.
- A new start is ignored while in BUSY or DONE.
- A start in the first IDLE cycle after DONE is accepted: back-to-back divides in consecutive instructions are supported.
- flushE in BUSY: go to IDLE next edge. No flagD pulse; result_d is unchanged; stall_div drops after that edge.
- flushE in DONE: flagD still pulses, but the pipeline discards the result; no state effect.
- Non-divide opcodes never start the unit.
- flagD is never asserted except in DONE.

Test Plan:
- DIVU 100/7 → after 34 cycles, flagD pulse and result_d=14; REMU same operands → result_d=2; stall_div high for exactly 33 cycles.
- DIV 0xFFFFFFF9(−7)/2 → result_d=0xFFFFFFFD(−3); REM same operands → 0xFFFFFFFF(−1); DIV 7/0xFFFFFFFE(−2) → 0xFFFFFFFD.
- DIV 0x12345678/0 → flagD in the cycle after start, result_d=0xFFFFFFFF; REMU 0x12345678/0 → 0x12345678; stall_div high for 1 cycle only.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0; DIVU same operands → 0 via the normal 34-cycle path.
- Assert rst at iteration 10 → all outputs 0 immediately, stall_div low. Then DIVU 0xFFFFFFFF/0x10 completes correctly → 0x0FFFFFFF.
- Assert flushE at iteration 5 → no flagD, result_d keeps its previous value. A second start (DIV) during BUSY is ignored; back-to-back DIVU 9/3 then REMU 9/4 → results 3 then 1, each with a single flagD pulse.
